// File: rtl/bure_mem_arbiter.sv
// rtl/bure_mem_arbiter.sv - fetch/data arbiter onto a single memory port with starvation guard and read timeout
module bure_mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_req,
    input  logic [ADDR_WIDTH-1:0] i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [DATA_WIDTH-1:0] o_if_rdata,
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [ADDR_WIDTH-1:0] i_d_addr,
    input  logic [DATA_WIDTH-1:0] i_d_wdata,
    output logic                  o_d_gnt,
    output logic                  o_d_rvalid,
    output logic [DATA_WIDTH-1:0] o_d_rdata,
    output logic                  o_mem_ren,
    output logic [ADDR_WIDTH-1:0] o_mem_raddr,
    output logic                  o_mem_wen,
    output logic                  o_mem_wdata_valid,
    output logic [ADDR_WIDTH-1:0] o_mem_waddr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_t                state, state_nxt;
    logic [3:0]            starve_cnt, starve_nxt;
    logic [7:0]            tmo_cnt, tmo_nxt;
    logic                  owner_d, owner_d_nxt;
    logic                  pick_if;
    logic                  if_gnt_nxt, d_gnt_nxt, ren_nxt, wen_nxt;
    logic                  if_rvalid_nxt, d_rvalid_nxt, timeout_nxt;
    logic [ADDR_WIDTH-1:0] raddr_nxt, waddr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt, if_rdata_nxt, d_rdata_nxt;

    // Write data valid is by definition the write strobe itself.
    assign o_mem_wdata_valid = o_mem_wen;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state, counters and next values of every registered output.
    always_comb begin
        state_nxt     = state;
        starve_nxt    = starve_cnt;
        tmo_nxt       = tmo_cnt;
        owner_d_nxt   = owner_d;
        if_gnt_nxt    = 1'b0;
        d_gnt_nxt     = 1'b0;
        ren_nxt       = 1'b0;
        wen_nxt       = 1'b0;
        if_rvalid_nxt = 1'b0;
        d_rvalid_nxt  = 1'b0;
        timeout_nxt   = 1'b0;
        raddr_nxt     = o_mem_raddr;
        waddr_nxt     = o_mem_waddr;
        wdata_nxt     = o_mem_wdata;
        if_rdata_nxt  = o_if_rdata;
        d_rdata_nxt   = o_d_rdata;
        // Data has priority unless fetch has been passed over too many times.
        pick_if       = i_if_req && (!i_d_req || (starve_cnt == STARVE_MAX));
        case (state)
            IDLE: begin
                if (!i_if_req) starve_nxt = 4'd0;
                if (i_if_req || i_d_req) begin
                    state_nxt = ISSUE;
                    if (pick_if) begin
                        owner_d_nxt = 1'b0;
                        if_gnt_nxt  = 1'b1;
                        ren_nxt     = 1'b1;
                        raddr_nxt   = i_if_addr;
                        starve_nxt  = 4'd0;
                    end else begin
                        owner_d_nxt = 1'b1;
                        d_gnt_nxt   = 1'b1;
                        if (i_if_req && (starve_cnt != STARVE_MAX))
                            starve_nxt = starve_cnt + 4'd1;
                        if (i_d_we) begin
                            wen_nxt   = 1'b1;
                            waddr_nxt = i_d_addr;
                            wdata_nxt = i_d_wdata;
                        end else begin
                            ren_nxt   = 1'b1;
                            raddr_nxt = i_d_addr;
                        end
                    end
                end
            end
            ISSUE: begin
                tmo_nxt   = 8'd0;
                state_nxt = o_mem_wen ? IDLE : WAIT_RD;
            end
            WAIT_RD: begin
                // A response on the timeout edge still counts as a real response.
                if (i_mem_rdata_valid) begin
                    state_nxt = IDLE;
                    if (owner_d) begin
                        d_rvalid_nxt = 1'b1;
                        d_rdata_nxt  = i_mem_rdata;
                    end else begin
                        if_rvalid_nxt = 1'b1;
                        if_rdata_nxt  = i_mem_rdata;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                    if (owner_d) begin
                        d_rvalid_nxt = 1'b1;
                        d_rdata_nxt  = '0;
                    end else begin
                        if_rvalid_nxt = 1'b1;
                        if_rdata_nxt  = '0;
                    end
                end else begin
                    tmo_nxt = tmo_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, transaction owner and all registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            starve_cnt  <= 4'd0;
            tmo_cnt     <= 8'd0;
            owner_d     <= 1'b0;
            o_if_gnt    <= 1'b0;
            o_d_gnt     <= 1'b0;
            o_mem_ren   <= 1'b0;
            o_mem_wen   <= 1'b0;
            o_if_rvalid <= 1'b0;
            o_d_rvalid  <= 1'b0;
            o_timeout   <= 1'b0;
            o_mem_raddr <= '0;
            o_mem_waddr <= '0;
            o_mem_wdata <= '0;
            o_if_rdata  <= '0;
            o_d_rdata   <= '0;
        end else begin
            starve_cnt  <= starve_nxt;
            tmo_cnt     <= tmo_nxt;
            owner_d     <= owner_d_nxt;
            o_if_gnt    <= if_gnt_nxt;
            o_d_gnt     <= d_gnt_nxt;
            o_mem_ren   <= ren_nxt;
            o_mem_wen   <= wen_nxt;
            o_if_rvalid <= if_rvalid_nxt;
            o_d_rvalid  <= d_rvalid_nxt;
            o_timeout   <= timeout_nxt;
            o_mem_raddr <= raddr_nxt;
            o_mem_waddr <= waddr_nxt;
            o_mem_wdata <= wdata_nxt;
            o_if_rdata  <= if_rdata_nxt;
            o_d_rdata   <= d_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_bure_mem_arbiter.sv
// tb/tb_bure_mem_arbiter.sv - scoreboard bench for bure_mem_arbiter
module tb_bure_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_addr = '0;
    logic        o_if_gnt, o_if_rvalid;
    logic [31:0] o_if_rdata;
    logic        i_d_req = 1'b0;
    logic        i_d_we = 1'b0;
    logic [31:0] i_d_addr = '0;
    logic [31:0] i_d_wdata = '0;
    logic        o_d_gnt, o_d_rvalid;
    logic [31:0] o_d_rdata;
    logic        o_mem_ren, o_mem_wen, o_mem_wdata_valid;
    logic [31:0] o_mem_raddr, o_mem_waddr, o_mem_wdata;
    logic        i_mem_rdata_valid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_timeout;

    bure_mem_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(4), .TIMEOUT(16)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
        .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
        .o_mem_ren(o_mem_ren), .o_mem_raddr(o_mem_raddr),
        .o_mem_wen(o_mem_wen), .o_mem_wdata_valid(o_mem_wdata_valid),
        .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata_valid(i_mem_rdata_valid), .i_mem_rdata(i_mem_rdata),
        .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        if_gnt, d_gnt, ren, wen, wdv, if_rv, d_rv, tmo;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          mem_on = 1'b0;
    int          mem_delay = 2;
    logic [31:0] mem_resp_data = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic ev_t ev_wr(input logic [31:0] a, input logic [31:0] d);
        ev_t v = '0;
        v.d_gnt = 1'b1; v.wen = 1'b1; v.wdv = 1'b1; v.addr = a; v.data = d;
        return v;
    endfunction

    function automatic ev_t ev_rd(input bit is_d, input logic [31:0] a);
        ev_t v = '0;
        if (is_d) v.d_gnt = 1'b1; else v.if_gnt = 1'b1;
        v.ren = 1'b1; v.addr = a;
        return v;
    endfunction

    function automatic ev_t ev_rv(input bit is_d, input logic [31:0] d, input bit tmo);
        ev_t v = '0;
        if (is_d) v.d_rv = 1'b1; else v.if_rv = 1'b1;
        v.tmo = tmo; v.data = d;
        return v;
    endfunction

    function automatic ev_t observe();
        ev_t v;
        v.if_gnt = o_if_gnt; v.d_gnt = o_d_gnt; v.ren = o_mem_ren; v.wen = o_mem_wen;
        v.wdv = o_mem_wdata_valid; v.if_rv = o_if_rvalid; v.d_rv = o_d_rvalid; v.tmo = o_timeout;
        v.addr = o_mem_ren ? o_mem_raddr : (o_mem_wen ? o_mem_waddr : 32'h0);
        v.data = o_mem_wen ? o_mem_wdata : (o_if_rvalid ? o_if_rdata : (o_d_rvalid ? o_d_rdata : 32'h0));
        return v;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle with any strobe is one observed event, checked against the queue head.
    initial begin : monitor
        ev_t a, e;
        forever begin
            @(negedge i_clk);
            if (!i_rst && (o_if_gnt || o_d_gnt || o_mem_ren || o_mem_wen || o_mem_wdata_valid ||
                           o_if_rvalid || o_d_rvalid || o_timeout)) begin
                a = observe();
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event act=%h exp=none", a);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        bad++;
                        $display("FAIL event act=%h exp=%h", a, e);
                    end
                end
            end
        end
    end

    // Memory model: answers a read mem_delay edges after the read enable edge.
    initial begin : mem_model
        forever begin
            @(negedge i_clk);
            if (mem_on && o_mem_ren) begin
                repeat (mem_delay - 1) @(negedge i_clk);
                i_mem_rdata_valid = 1'b1;
                i_mem_rdata       = mem_resp_data;
                @(negedge i_clk);
                i_mem_rdata_valid = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic wait_gnt(input bit is_d, input string name, output int n);
        n = 0;
        @(negedge i_clk);
        while (!(is_d ? o_d_gnt : o_if_gnt) && n < 60) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 60) begin
            total++; bad++;
            $display("FAIL %s grant wait expired", name);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        repeat (3) @(negedge i_clk);
        check(name, 160'(exp_q.size()), 160'd0);
    endtask

    function automatic logic [159:0] bus_vec();
        return {o_if_rdata, o_d_rdata, o_mem_raddr, o_mem_waddr, o_mem_wdata};
    endfunction

    function automatic logic [159:0] flag_vec();
        return 160'({o_if_gnt, o_if_rvalid, o_d_gnt, o_d_rvalid, o_mem_ren, o_mem_wen,
                     o_mem_wdata_valid, o_timeout});
    endfunction

    initial begin : stim
        int n, g, dn, ifn, guard, c0, c1;
        c0 = 0; c1 = 0;
        // Reset state
        #1;
        check("reset_flags", flag_vec(), 160'd0);
        check("reset_buses", bus_vec(), 160'd0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;

        // Single data write
        @(negedge i_clk);
        i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 32'h0; i_d_wdata = 32'h0000_0114;
        exp_q.push_back(ev_wr(32'h0, 32'h0000_0114));
        wait_gnt(1'b1, "wr", n);
        i_d_req = 1'b0;
        wait_drain("drain_write");

        // Fetch read with a memory response
        mem_on = 1'b1; mem_delay = 2; mem_resp_data = 32'h0000_0214;
        i_if_req = 1'b1; i_if_addr = 32'h1;
        exp_q.push_back(ev_rd(1'b0, 32'h1));
        exp_q.push_back(ev_rv(1'b0, 32'h0000_0214, 1'b0));
        wait_gnt(1'b0, "if_rd", n);
        i_if_req = 1'b0;
        wait_drain("drain_if_read");
        check("if_rdata_hold", 160'(o_if_rdata), 160'h0000_0214);

        // Both requesting: D,D,D,D,IF,D,D,D,D,IF
        mem_resp_data = 32'hA5A5_0001; i_if_addr = 32'h40;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(ev_wr(32'h10 + 32'(k), 32'hD000_0000 + 32'(k)));
            if (k == 3 || k == 7) begin
                exp_q.push_back(ev_rd(1'b0, 32'h40));
                exp_q.push_back(ev_rv(1'b0, 32'hA5A5_0001, 1'b0));
            end
        end
        i_if_req = 1'b1; i_d_req = 1'b1; i_d_we = 1'b1;
        i_d_addr = 32'h10; i_d_wdata = 32'hD000_0000;
        dn = 0; ifn = 0; guard = 0;
        while (ifn < 2 && guard < 200) begin
            @(negedge i_clk);
            guard++;
            if (o_d_gnt) begin
                if (dn == 0) c0 = cyc;
                if (dn == 1) c1 = cyc;
                dn++;
                i_d_addr  = 32'h10 + 32'(dn);
                i_d_wdata = 32'hD000_0000 + 32'(dn);
            end
            if (o_if_gnt) ifn++;
        end
        i_if_req = 1'b0; i_d_req = 1'b0;
        check("starve_grants_done", 160'(guard < 200), 160'd1);
        check("write_spacing", 160'(c1 - c0), 160'd2);
        wait_drain("drain_starve");

        // Data read with a response, so the timeout below must clear a nonzero rdata
        mem_resp_data = 32'h0000_5A5A;
        i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h21;
        exp_q.push_back(ev_rd(1'b1, 32'h21));
        exp_q.push_back(ev_rv(1'b1, 32'h0000_5A5A, 1'b0));
        wait_gnt(1'b1, "d_rd", n);
        i_d_req = 1'b0;
        wait_drain("drain_d_read");

        // Data read, no response: timeout after 16 WAIT_RD cycles
        mem_on = 1'b0;
        i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h22;
        exp_q.push_back(ev_rd(1'b1, 32'h22));
        exp_q.push_back(ev_rv(1'b1, 32'h0, 1'b1));
        wait_gnt(1'b1, "d_tmo", n);
        g = cyc;
        i_d_req = 1'b0;
        n = 0;
        while (!o_timeout && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        check("timeout_latency", 160'(cyc - g), 160'd17);
        @(negedge i_clk);
        i_mem_rdata_valid = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
        @(negedge i_clk);
        i_mem_rdata_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        check("stray_dropped", 160'({o_d_rvalid, o_d_rdata}), 160'd0);
        wait_drain("drain_timeout");

        // Response on the timeout edge wins
        mem_on = 1'b1; mem_delay = 17; mem_resp_data = 32'h0000_0C0D;
        i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h23;
        exp_q.push_back(ev_rd(1'b1, 32'h23));
        exp_q.push_back(ev_rv(1'b1, 32'h0000_0C0D, 1'b0));
        wait_gnt(1'b1, "d_race", n);
        i_d_req = 1'b0;
        wait_drain("drain_race");
        mem_delay = 2;

        // Reset during WAIT_RD, late response, pending fetch served after release
        mem_on = 1'b0;
        i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h33;
        exp_q.push_back(ev_rd(1'b1, 32'h33));
        wait_gnt(1'b1, "d_rst", n);
        i_d_req = 1'b0;
        repeat (3) @(negedge i_clk);
        i_if_req = 1'b1; i_if_addr = 32'h44;
        i_rst = 1'b1;
        #1;
        check("rst_async_flags", flag_vec(), 160'd0);
        check("rst_async_buses", bus_vec(), 160'd0);
        @(negedge i_clk);
        check("rst_held_flags", flag_vec(), 160'd0);
        i_rst = 1'b0;
        mem_on = 1'b1; mem_resp_data = 32'h0000_0777;
        i_mem_rdata_valid = 1'b1; i_mem_rdata = 32'h0000_0BAD;
        exp_q.push_back(ev_rd(1'b0, 32'h44));
        exp_q.push_back(ev_rv(1'b0, 32'h0000_0777, 1'b0));
        wait_gnt(1'b0, "if_after_rst", n);
        i_mem_rdata_valid = 1'b0;
        i_if_req = 1'b0;
        check("first_edge_after_rst", 160'(n), 160'd0);
        wait_drain("drain_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
